bus_arbiter8: RTL
=================

# bus_arbiter8

Round-robin arbiter that shares the CPU's 8-input data-bus multiplexer between up to eight requesters. It takes request lines from the bus masters and issues a one-hot grant. It also drives the 3-bit select of the 8:1 mux so the granted source's data reaches the shared bus. It sits between the bus masters and the mux, and the bus consumer's completion strobe ends each tenure.

## Interface

- `HOLD_MAX`, default 16: maximum cycles a grant may be held when the timeout feature is compiled in (legal range 2..255).
- `CLK` in 1: system clock; all state updates on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `REQ` in 8: request per master; bit i = master i; level-sensitive, held until granted and served.
- `DONE` in 1: consumer strobe; high for one cycle marks the end of the current transfer.
- `GNT` out 8: one-hot grant, or all zeros; registered.
- `SEL` out 3: mux select, equal to the binary index of the current or last owner; registered.
- `BUSY` out 1: high while in GRANT state; registered.
- `TIMEOUT` out 1: one-cycle pulse when a grant is revoked by the watchdog; registered; tied 0 if the feature is compiled out.

## Operation

- States: IDLE, GRANT.
- Internal `last` pointer (3 bits) holds the index of the most recent owner. Reset value is 7, so master 0 has first priority after reset.
- IDLE:
  - GNT=0, BUSY=0.
  - If REQ≠0, the winner is the first set bit searching upward from `last`+1, modulo 8.
  - Next state is GRANT with GNT[w]=1 and SEL=w.
  - If REQ=0, stay in IDLE; SEL keeps its value.
- GRANT:
  - GNT, SEL and `owner` are held stable.
  - The hold counter increments each cycle.
- Release conditions, evaluated each GRANT cycle:
  - (a) DONE=1;
  - (b) REQ[owner]=0, meaning the master abandoned the transfer;
  - (c) timeout (see Configuration).
- On any release:
  - Next state is IDLE, GNT=0, BUSY=0, `last`=owner, and the counter clears.
  - Multiple release conditions in the same cycle produce a single release.
  - TIMEOUT pulses only when (c) is the sole cause.
- A mandatory IDLE cycle always separates two grants, so there are no back-to-back grants and no overlap on the bus.
- DONE sampled in IDLE is ignored.
- REQ changes on non-owner bits during GRANT have no effect until the next IDLE evaluation.
- Counter width is 8 bits and saturates; it never wraps.
- GNT is never multi-hot, and GNT≠0 exactly when BUSY=1.
- SEL always equals the index of the set GNT bit whenever GNT≠0.

## Timing

- Reset values: GNT=0, SEL=0, BUSY=0, TIMEOUT=0, state IDLE, `last`=7, counter 0.
- Reset asserted mid-grant: all outputs return to their reset values immediately and asynchronously. No TIMEOUT pulse is generated.
- Request to grant: REQ is sampled at edge k in IDLE, and GNT/SEL/BUSY are valid after edge k. Minimum latency is 1 cycle from IDLE.
- Release: DONE is sampled high at edge k, and GNT=0 after edge k. The next grant can appear after edge k+1 at the earliest.
- Fairness: with all 8 requesting continuously, each master is granted once every 8 tenures, in ascending index order with wrap from 7 to 0.
- SEL changes only on the edge that enters GRANT. Downstream mux output is therefore stable throughout the tenure.

## Configuration

- Macro: `BUS_ARBITER8_TIMEOUT_EN`.
- Defined:
  - The hold counter is compared against HOLD_MAX.
  - If the owner has held GNT for HOLD_MAX cycles without DONE, the grant is revoked on the edge ending cycle HOLD_MAX.
  - TIMEOUT=1 for exactly the following cycle (the IDLE cycle), and `last` is set to the owner.
- Undefined:
  - No counter or comparator logic.
  - TIMEOUT is constant 0.
  - A grant is held indefinitely until DONE or the owner drops REQ.

## Test plan

- Reset then REQ=8'h00 for 10 cycles -> GNT=0, SEL=0, BUSY=0 throughout.
- After reset, REQ=8'h24 held, DONE pulsed 3 cycles after each grant -> grants alternate GNT=8'h04 (SEL=2), then 8'h20 (SEL=5), then 8'h04, with one IDLE cycle between each.
- REQ=8'hFF held, DONE on every GRANT cycle -> grant sequence 0,1,2,…,7,0. Grants are exactly 1 cycle wide with a 1-cycle gap, and GNT is never multi-hot.
- Owner 3 granted, REQ[3] dropped while DONE=0 -> GNT=0 on the next edge, `last`=3, and TIMEOUT stays 0. If REQ=8'h09 persists, the next grant goes to 0.
- With `BUS_ARBITER8_TIMEOUT_EN` and HOLD_MAX=4: master 6 granted, DONE never asserted -> GNT=8'h40 for exactly 4 cycles, then GNT=0 with TIMEOUT=1 for 1 cycle. With REQ[6] still high, master 6 is regranted only if no other master requests.
- RST asserted between edges while GNT=8'h10 -> GNT, SEL, BUSY go to 0 without waiting for a clock edge. After release, REQ=8'h10 is granted with SEL=4 one edge later.

Source files
------------

// File: rtl/bus_arbiter8_if.sv
// Request/grant bundle between the bus masters and the 8:1 data-bus mux arbiter.
// The master modport is the arbiter side; slave is the masters/consumer side.
interface bus_arbiter8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;

  modport master (
    input  req,
    input  done,
    output gnt,
    output sel,
    output busy,
    output timeout
  );

  modport slave (
    output req,
    output done,
    input  gnt,
    input  sel,
    input  busy,
    input  timeout
  );
endinterface

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter for the shared 8:1 data-bus mux: one-hot grant plus registered mux select.
// Optional hold watchdog compiled in with `define BUS_ARBITER8_TIMEOUT_EN (limit HOLD_MAX cycles).
module bus_arbiter8 #(
  parameter int HOLD_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter8_if.master bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [2:0] last_q, last_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;
  logic [2:0] win;
  logic       rel_nat;
  logic       hold_expired;

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
    $error("HOLD_MAX must be in 2..255");
  end

  // First requester strictly after the previous owner, wrapping 7 -> 0.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
    logic [2:0] idx;
    logic [2:0] w;
    logic       found;
    w     = last;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = last + 3'(i);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign win     = rr_pick(bus.req, last_q);
  assign rel_nat = (state_q == GRANT) && (bus.done || !bus.req[sel_q]);

`ifdef BUS_ARBITER8_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       to_q, to_d;

  // cnt_q counts completed grant cycles, so it reads HOLD_MAX-1 during the last allowed one.
  assign hold_expired = (state_q == GRANT) && (cnt_q >= 8'(HOLD_MAX - 1));

  always_comb begin
    cnt_d = 8'd0;
    to_d  = 1'b0;
    if (state_q == GRANT) begin
      if (rel_nat || hold_expired) begin
        cnt_d = 8'd0;
        to_d  = hold_expired && !rel_nat;
      end else begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign bus.timeout = to_q;
`else
  assign hold_expired = 1'b0;
  assign bus.timeout  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.req != 8'd0) begin
          state_d = GRANT;
          sel_d   = win;
          gnt_d   = 8'd1 << win;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        if (rel_nat || hold_expired) begin
          state_d = IDLE;
          gnt_d   = 8'd0;
          busy_d  = 1'b0;
          last_d  = sel_q;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 8'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 3'd7;
      sel_q   <= 3'd0;
      gnt_q   <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;

endmodule
